// File: rtl/usb_pkg.sv
// ---------------------------------------------------------------------------
// usb_pkg
// Shared definitions for the USB full-speed transmit path:
//   - tx_packet request encoding (tx_packet_t)
//   - transmit FSM state encoding (tx_state_t)
//   - SYNC byte, PID bytes, CRC16 polynomial/init, maximum data payload
//   - CRC16 serial update helper (bits arrive LSB-first)
// ---------------------------------------------------------------------------
package usb_pkg;

  typedef enum logic [1:0] {
    PKT_NONE  = 2'b00,
    PKT_DATA0 = 2'b01,
    PKT_ACK   = 2'b10,
    PKT_NAK   = 2'b11
  } tx_packet_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_DATA,
    ST_CRC_LO,
    ST_CRC_HI,
    ST_EOP_SE0,
    ST_EOP_J
  } tx_state_t;

  localparam logic [7:0]  SYNC_BYTE  = 8'h80;
  localparam logic [7:0]  PID_DATA0  = 8'hC3;
  localparam logic [7:0]  PID_ACK    = 8'hD2;
  localparam logic [7:0]  PID_NAK    = 8'h5A;
  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;
  localparam logic [6:0]  MAX_PACKET = 7'd64;
  localparam logic [2:0]  STUFF_RUN  = 3'd6;

  function automatic logic [15:0] reflect16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) begin
      r[i] = v[15-i];
    end
    return r;
  endfunction

  // Data goes out LSB-first, so the register is kept bit-reversed: it shifts
  // right and folds in the reflected polynomial. The complemented register
  // then leaves the wire low byte first, LSB-first, with no further reordering.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic [15:0] nxt;
    nxt = {1'b0, crc[15:1]};
    if (crc[0] ^ din) begin
      nxt = nxt ^ reflect16(CRC16_POLY);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/usb_tx_timer.sv
// ---------------------------------------------------------------------------
// usb_tx_timer
// Bit-time strobe generator: 12 Mb/s from a 100 MHz clock, bit periods of
// 8, 8, 9 clocks repeating (25 clocks per 3 bits). Disabling clears the
// count and phase so that the pattern restarts at the next enable.
// Ports:
//   clk        system clock
//   n_rst      asynchronous active-low reset
//   enable     run the timer (held high for the whole packet)
//   bit_strobe high for one clock in the last cycle of each bit time
// ---------------------------------------------------------------------------
module usb_tx_timer (
  input  logic clk,
  input  logic n_rst,
  input  logic enable,
  output logic bit_strobe
);

  logic [3:0] count;
  logic [1:0] phase;
  logic [3:0] last;

  always_comb begin
    last       = (phase == 2'd2) ? 4'd8 : 4'd7;
    bit_strobe = enable && (count == last);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
      phase <= '0;
    end else if (!enable) begin
      count <= '0;
      phase <= '0;
    end else if (bit_strobe) begin
      count <= '0;
      phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
    end else begin
      count <= count + 4'd1;
    end
  end

endmodule

// File: rtl/usb_tx_encoder.sv
// ---------------------------------------------------------------------------
// usb_tx_encoder
// USB full-speed packet transmitter: SYNC, PID, optional DATA0 payload with
// CRC16, bit stuffing, NRZI line coding and EOP.
// Ports:
//   clk                 system clock (100 MHz)
//   n_rst               asynchronous active-low reset
//   tx_packet           request: 00 none, 01 DATA0, 10 ACK, 11 NAK (IDLE only)
//   buffer_occupancy    bytes waiting in the TX buffer (latched at accept)
//   tx_packet_data      show-ahead head byte of the TX buffer
//   get_tx_packet_data  one-cycle pop strobe, in the cycle a byte is loaded
//   dplus_out           registered D+ drive
//   dminus_out          registered D- drive
//   tx_transfer_active  high from accept through the end of EOP
//   tx_error            one-cycle pulse when a DATA0 request is too long
// ---------------------------------------------------------------------------
module usb_tx_encoder
  import usb_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic [1:0] tx_packet,
  input  logic [6:0] buffer_occupancy,
  input  logic [7:0] tx_packet_data,
  output logic       get_tx_packet_data,
  output logic       dplus_out,
  output logic       dminus_out,
  output logic       tx_transfer_active,
  output logic       tx_error
);

  tx_state_t   state, state_nxt;
  tx_packet_t  kind, kind_nxt;
  logic [6:0]  byte_cnt, byte_cnt_nxt;
  logic [7:0]  shifter, shifter_nxt;
  logic [2:0]  bit_cnt, bit_cnt_nxt;
  logic [2:0]  ones_cnt, ones_cnt_nxt;
  logic [15:0] crc, crc_nxt;
  logic        lvl, lvl_nxt;
  logic        dplus_nxt, dminus_nxt, active_nxt, error_nxt;
  logic        bit_strobe, serial_state, timer_en;
  logic        send_en, send_bit, crc_en, load_en;
  logic [7:0]  load_byte;

  function automatic logic [7:0] pid_of(input tx_packet_t k);
    case (k)
      PKT_DATA0: return PID_DATA0;
      PKT_ACK:   return PID_ACK;
      default:   return PID_NAK;
    endcase
  endfunction

  assign timer_en = (state != ST_IDLE);

  usb_tx_timer u_timer (
    .clk        (clk),
    .n_rst      (n_rst),
    .enable     (timer_en),
    .bit_strobe (bit_strobe)
  );

  always_comb begin
    state_nxt          = state;
    kind_nxt           = kind;
    byte_cnt_nxt       = byte_cnt;
    shifter_nxt        = shifter;
    bit_cnt_nxt        = bit_cnt;
    ones_cnt_nxt       = ones_cnt;
    crc_nxt            = crc;
    lvl_nxt            = lvl;
    dplus_nxt          = dplus_out;
    dminus_nxt         = dminus_out;
    active_nxt         = tx_transfer_active;
    error_nxt          = 1'b0;
    get_tx_packet_data = 1'b0;
    send_en            = 1'b0;
    send_bit           = 1'b0;
    crc_en             = 1'b0;
    load_en            = 1'b0;
    load_byte          = '0;
    serial_state       = (state == ST_SYNC) || (state == ST_PID) || (state == ST_DATA) ||
                         (state == ST_CRC_LO) || (state == ST_CRC_HI);

    if (state == ST_IDLE) begin
      if (tx_packet != PKT_NONE) begin
        if ((tx_packet == PKT_DATA0) && (buffer_occupancy > MAX_PACKET)) begin
          error_nxt = 1'b1;
        end else begin
          // The first SYNC bit is driven on the accept edge itself.
          state_nxt    = ST_SYNC;
          kind_nxt     = tx_packet_t'(tx_packet);
          byte_cnt_nxt = buffer_occupancy;
          crc_nxt      = CRC16_INIT;
          active_nxt   = 1'b1;
          load_en      = 1'b1;
          load_byte    = SYNC_BYTE;
        end
      end
    end else if (bit_strobe) begin
      if (serial_state && (ones_cnt == STUFF_RUN)) begin
        // Stuffed zero: shifter, bit counter and CRC hold for this bit time.
        send_en  = 1'b1;
        send_bit = 1'b0;
      end else if (serial_state && (bit_cnt != 3'd7)) begin
        shifter_nxt = {1'b0, shifter[7:1]};
        bit_cnt_nxt = bit_cnt + 3'd1;
        send_en     = 1'b1;
        send_bit    = shifter[1];
        crc_en      = (state == ST_DATA);
      end else begin
        case (state)
          ST_SYNC: begin
            state_nxt = ST_PID;
            load_en   = 1'b1;
            load_byte = pid_of(kind);
          end
          ST_PID, ST_DATA: begin
            if ((state == ST_PID) && (kind != PKT_DATA0)) begin
              state_nxt = ST_EOP_SE0;
            end else if (byte_cnt != '0) begin
              state_nxt          = ST_DATA;
              load_en            = 1'b1;
              load_byte          = tx_packet_data;
              crc_en             = 1'b1;
              get_tx_packet_data = 1'b1;
              byte_cnt_nxt       = byte_cnt - 7'd1;
            end else begin
              state_nxt = ST_CRC_LO;
              load_en   = 1'b1;
              load_byte = ~crc[7:0];
            end
          end
          ST_CRC_LO: begin
            state_nxt = ST_CRC_HI;
            load_en   = 1'b1;
            load_byte = ~crc[15:8];
          end
          ST_CRC_HI: begin
            state_nxt = ST_EOP_SE0;
          end
          ST_EOP_SE0: begin
            if (bit_cnt == 3'd0) begin
              bit_cnt_nxt = 3'd1;
            end else begin
              state_nxt  = ST_EOP_J;
              lvl_nxt    = 1'b1;
              dplus_nxt  = 1'b1;
              dminus_nxt = 1'b0;
            end
          end
          ST_EOP_J: begin
            state_nxt  = ST_IDLE;
            active_nxt = 1'b0;
          end
          default: begin
            state_nxt = ST_IDLE;
          end
        endcase

        if ((state_nxt == ST_EOP_SE0) && (state != ST_EOP_SE0)) begin
          dplus_nxt    = 1'b0;
          dminus_nxt   = 1'b0;
          bit_cnt_nxt  = 3'd0;
          ones_cnt_nxt = 3'd0;
        end
      end
    end

    if (load_en) begin
      shifter_nxt = load_byte;
      bit_cnt_nxt = 3'd0;
      send_en     = 1'b1;
      send_bit    = load_byte[0];
    end

    // NRZI: a zero toggles the line, a one holds it.
    if (send_en) begin
      ones_cnt_nxt = send_bit ? ones_cnt + 3'd1 : 3'd0;
      lvl_nxt      = send_bit ? lvl : ~lvl;
      dplus_nxt    = lvl_nxt;
      dminus_nxt   = ~lvl_nxt;
      if (crc_en) begin
        crc_nxt = crc16_step(crc, send_bit);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state              <= ST_IDLE;
      kind               <= PKT_NONE;
      byte_cnt           <= '0;
      shifter            <= '0;
      bit_cnt            <= '0;
      ones_cnt           <= '0;
      crc                <= CRC16_INIT;
      lvl                <= 1'b1;
      dplus_out          <= 1'b1;
      dminus_out         <= 1'b0;
      tx_transfer_active <= 1'b0;
      tx_error           <= 1'b0;
    end else begin
      state              <= state_nxt;
      kind               <= kind_nxt;
      byte_cnt           <= byte_cnt_nxt;
      shifter            <= shifter_nxt;
      bit_cnt            <= bit_cnt_nxt;
      ones_cnt           <= ones_cnt_nxt;
      crc                <= crc_nxt;
      lvl                <= lvl_nxt;
      dplus_out          <= dplus_nxt;
      dminus_out         <= dminus_nxt;
      tx_transfer_active <= active_nxt;
      tx_error           <= error_nxt;
    end
  end

endmodule

// File: tb/tb_usb_tx_encoder.sv
// ---------------------------------------------------------------------------
// tb_usb_tx_encoder
// Scoreboard bench for usb_tx_encoder: each request pushes its expected
// packet (bytes, wire bit times, pop count) into queues; an independent wire
// monitor NRZI-decodes and unstuffs the bus and compares against them.
// ---------------------------------------------------------------------------
module tb_usb_tx_encoder;

  logic       tb_clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [1:0] tx_packet = 2'b00;
  logic [6:0] buffer_occupancy = 7'd0;
  logic [7:0] tx_packet_data = 8'h00;
  logic       get_tx_packet_data;
  logic       dplus_out;
  logic       dminus_out;
  logic       tx_transfer_active;
  logic       tx_error;

  usb_tx_encoder dut (
    .clk                (tb_clk),
    .n_rst              (n_rst),
    .tx_packet          (tx_packet),
    .buffer_occupancy   (buffer_occupancy),
    .tx_packet_data     (tx_packet_data),
    .get_tx_packet_data (get_tx_packet_data),
    .dplus_out          (dplus_out),
    .dminus_out         (dminus_out),
    .tx_transfer_active (tx_transfer_active),
    .tx_error           (tx_error)
  );

  always #5 tb_clk = ~tb_clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pops = 0;
  int pkts_done = 0;

  logic [7:0] fifo_q[$];
  logic       pop_pend = 1'b0;

  int         exp_len_q[$];
  logic [7:0] exp_byte_q[$];
  int         exp_bits_q[$];
  int         exp_pops_q[$];

  always @(posedge tb_clk) cyc = cyc + 1;

  // Show-ahead buffer model: a pop seen in one cycle retires the head at the
  // following negedge, after the DUT has captured it.
  always @(negedge tb_clk) begin
    if (pop_pend && (fifo_q.size() > 0)) void'(fifo_q.pop_front());
    pop_pend = get_tx_packet_data;
    if (get_tx_packet_data) pops = pops + 1;
    tx_packet_data = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_crc(input logic [7:0] d[$]);
    logic [15:0] n;
    logic [15:0] r;
    logic        fb;
    n = 16'hFFFF;
    foreach (d[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb = d[i][b] ^ n[15];
        n  = {n[14:0], 1'b0};
        if (fb) n = n ^ 16'h8005;
      end
    end
    for (int i = 0; i < 16; i++) r[i] = n[15-i];
    return ~r;
  endfunction

  function automatic int wire_bits(input logic [7:0] d[$]);
    int n;
    int ones;
    n = 0;
    ones = 0;
    foreach (d[i]) begin
      for (int b = 0; b < 8; b++) begin
        n = n + 1;
        if (d[i][b]) ones = ones + 1;
        else ones = 0;
        if (ones == 6) begin
          n = n + 1;
          ones = 0;
        end
      end
    end
    return n + 3;
  endfunction

  task automatic issue(input logic [1:0] kind, input logic [7:0] payload[$], input int occ,
                       input bit expect_it);
    logic [7:0]  bytes[$];
    logic [15:0] c;
    bytes.push_back(8'h80);
    case (kind)
      2'b01:   bytes.push_back(8'hC3);
      2'b10:   bytes.push_back(8'hD2);
      default: bytes.push_back(8'h5A);
    endcase
    if (kind == 2'b01) begin
      foreach (payload[i]) bytes.push_back(payload[i]);
      c = ref_crc(payload);
      bytes.push_back(c[7:0]);
      bytes.push_back(c[15:8]);
      foreach (payload[i]) fifo_q.push_back(payload[i]);
    end
    if (expect_it) begin
      exp_len_q.push_back(bytes.size());
      foreach (bytes[i]) exp_byte_q.push_back(bytes[i]);
      exp_bits_q.push_back(wire_bits(bytes));
      exp_pops_q.push_back((kind == 2'b01) ? payload.size() : 0);
    end
    @(negedge tb_clk);
    buffer_occupancy = occ[6:0];
    tx_packet = kind;
    @(negedge tb_clk);
    tx_packet = 2'b00;
    check("accept_first_bit", {29'd0, tx_transfer_active, dplus_out, dminus_out}, 32'h5);
  endtask

  task automatic wait_done(input int n);
    int t;
    t = 0;
    while ((pkts_done < n) && (t < 20000)) begin
      @(negedge tb_clk);
      t = t + 1;
    end
    check("packet_complete", pkts_done, n);
  endtask

  // Wire monitor
  initial begin : monitor
    logic       bits[$];
    logic       prev, lvl, b;
    logic [7:0] g, e;
    int         start, k, ones, se0, pop0, nbytes, en;
    bit         done, aborted;
    forever begin
      @(negedge tb_clk);
      if (n_rst && !dplus_out && dminus_out) begin
        start = cyc;
        pop0 = pops;
        prev = 1'b1;
        ones = 0;
        se0 = 0;
        k = 0;
        done = 0;
        aborted = 0;
        bits.delete();
        while (!done && !aborted) begin
          while ((cyc != start + 8 * k + k / 3 + 4) && n_rst) @(negedge tb_clk);
          if (!n_rst) begin
            aborted = 1;
          end else if (!dplus_out && !dminus_out) begin
            se0 = se0 + 1;
          end else if (se0 != 0) begin
            done = 1;
            check("eop_j_line", {30'd0, dplus_out, dminus_out}, 32'h2);
            check("active_during_eop_j", {31'd0, tx_transfer_active}, 32'h1);
          end else begin
            lvl = dplus_out;
            b = (lvl == prev);
            prev = lvl;
            if (ones == 6) begin
              check("stuff_bit", {31'd0, b}, 32'h0);
              ones = 0;
            end else begin
              bits.push_back(b);
              ones = b ? ones + 1 : 0;
            end
          end
          k = k + 1;
          if (k > 1200) begin
            check("bit_budget", 32'd1, 32'd0);
            aborted = 1;
          end
        end
        if (done) begin
          if (exp_len_q.size() == 0) begin
            check("unexpected_packet", 32'd1, 32'd0);
          end else begin
            en = exp_len_q.pop_front();
            nbytes = bits.size() / 8;
            check("packet_bytes", nbytes, en);
            for (int j = 0; j < en; j++) begin
              e = exp_byte_q.pop_front();
              g = 8'h00;
              if (j < nbytes) for (int i = 0; i < 8; i++) g[i] = bits[j*8+i];
              check("packet_byte", {24'd0, g}, {24'd0, e});
            end
            check("wire_bit_times", k, exp_bits_q.pop_front());
            check("se0_bit_times", se0, 2);
            check("pop_count", pops - pop0, exp_pops_q.pop_front());
          end
          while (cyc != start + 8 * k + k / 3) @(negedge tb_clk);
          check("idle_after_eop", {29'd0, tx_transfer_active, dplus_out, dminus_out}, 32'h2);
          pkts_done = pkts_done + 1;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [7:0] pl[$];
    int p0, t;
    repeat (3) @(negedge tb_clk);
    check("reset_outputs", {27'd0, dplus_out, dminus_out, tx_transfer_active, tx_error,
                            get_tx_packet_data}, 32'h10);
    n_rst = 1'b1;
    repeat (2) @(negedge tb_clk);

    // ACK: 19 bit times, no pops
    pl.delete();
    issue(2'b10, pl, 0, 1);
    wait_done(1);

    // zero-length DATA0: CRC 0x0000
    issue(2'b01, pl, 0, 1);
    wait_done(2);

    // all-ones payload exercises stuffing
    pl.delete();
    pl.push_back(8'hFF);
    pl.push_back(8'hFF);
    issue(2'b01, pl, 2, 1);
    wait_done(3);

    // distinct bytes check order on the wire
    pl.delete();
    pl.push_back(8'h01);
    pl.push_back(8'h80);
    pl.push_back(8'h3C);
    issue(2'b01, pl, 3, 1);
    wait_done(4);

    // maximum packet; occupancy drop mid-transfer must be ignored
    pl.delete();
    repeat (64) pl.push_back(8'h75);
    issue(2'b01, pl, 64, 1);
    repeat (300) @(negedge tb_clk);
    buffer_occupancy = 7'd0;
    wait_done(5);

    // over-long DATA0 rejected
    @(negedge tb_clk);
    buffer_occupancy = 7'd65;
    tx_packet = 2'b01;
    p0 = pops;
    @(negedge tb_clk);
    tx_packet = 2'b00;
    check("tx_error_pulse", {31'd0, tx_error}, 32'h1);
    check("reject_lines_j", {29'd0, tx_transfer_active, dplus_out, dminus_out}, 32'h2);
    @(negedge tb_clk);
    check("tx_error_one_cycle", {31'd0, tx_error}, 32'h0);
    repeat (20) @(negedge tb_clk);
    check("reject_no_pops", pops - p0, 0);
    check("reject_stays_idle", {29'd0, tx_transfer_active, dplus_out, dminus_out}, 32'h2);

    // NAK with tx_packet disturbed mid-transfer
    pl.delete();
    issue(2'b11, pl, 0, 1);
    repeat (40) @(negedge tb_clk);
    tx_packet = 2'b01;
    buffer_occupancy = 7'd5;
    repeat (20) @(negedge tb_clk);
    tx_packet = 2'b00;
    wait_done(6);

    // reset in the middle of the payload, at the tenth byte
    pl.delete();
    for (int i = 0; i < 20; i++) pl.push_back(8'(i * 7 + 3));
    p0 = pops;
    issue(2'b01, pl, 20, 0);
    t = 0;
    while ((pops - p0 < 10) && (t < 5000)) begin
      @(negedge tb_clk);
      t = t + 1;
    end
    check("reached_byte_10", pops - p0, 10);
    @(posedge tb_clk);
    #2;
    n_rst = 1'b0;
    #1;
    check("reset_mid_lines", {28'd0, dplus_out, dminus_out, tx_transfer_active,
                              get_tx_packet_data}, 32'h8);
    p0 = pops;
    repeat (3) @(negedge tb_clk);
    fifo_q.delete();
    n_rst = 1'b1;
    repeat (30) @(negedge tb_clk);
    check("no_pops_after_reset", pops - p0, 0);
    check("idle_after_reset", {29'd0, tx_transfer_active, dplus_out, dminus_out}, 32'h2);
    pl.delete();
    issue(2'b10, pl, 0, 1);
    wait_done(7);

    check("scoreboard_empty", exp_len_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
